fb_line_drawer: RTL and testbench
=================================

# fb_line_drawer

Rasterises one vector (x0,y0)→(x1,y1) per command into framebuffer pixel writes using Bresenham stepping, one pixel per clock. Sits directly upstream of the triple-buffered framebuffer controller and drives its write port (`w_addr`, `color_in`, `en_w`). It also generates the end-of-frame `done` strobe that makes the controller rotate buffers. Commands come from the vector-list processor.

## Interface
- `H_RES`, 640, visible columns
- `V_RES`, 480, visible rows
- `ADDR_W`, 19, framebuffer address width
- `COLOR_W`, 4, pixel colour width
- `CW`, 11, signed coordinate width (covers -1024..1023)

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; accepted only when `busy`=0.
- `x0`, `y0`, `x1`, `y1`  in  CW each  signed endpoints, sampled on accept.
- `color`  in  COLOR_W  line colour, sampled on accept.
- `frame_end`  in  1  pulse: the vector list for this frame is complete.
- `busy`  out  1  line in progress; `start` is ignored while high.
- `line_done`  out  1  one-cycle pulse coincident with the last write slot of a line.
- `w_addr`  out  ADDR_W  pixel address, y*H_RES+x.
- `color_in`  out  COLOR_W  pixel colour.
- `en_w`  out  1  write strobe.
- `done`  out  1  one-cycle end-of-frame pulse toward the framebuffer controller.

## Operation
- States:
  - IDLE: on `start` → SETUP.
  - SETUP: one cycle. Compute dx=|x1-x0|, dy=-|y1-y0|, sx, sy=±1, err=dx+dy, and remaining count n=max(dx,-dy). Go to DRAW.
  - DRAW: every cycle, emit the current (x,y), then step.
    - e2=2·err.
    - If e2≥dy: err+=dy, x+=sx.
    - If e2≤dx: err+=dx, y+=sy.
    - When the pixel with n=0 has been emitted → IDLE.
- Pixel count is always n+1. A zero-length line emits exactly one pixel.
- Arithmetic widths:
  - dx, dy, err: CW+2 bits signed.
  - e2: CW+3 bits signed.
  - No overflow is possible for any in-range endpoint.
- Clipping: a pixel outside 0≤x<H_RES, 0≤y<V_RES still occupies its cycle but produces `en_w`=0. Off-screen lines are never aborted.
- Address pipeline: one registered stage computes `w_addr`. `w_addr`, `color_in`, `en_w` and `line_done` are all registered.
- Frame end:
  - `frame_end` sets a pending latch.
  - `done` pulses for one cycle when pending=1 and the drawer is idle with its write pipeline empty. Pending clears on that same cycle.
  - `frame_end` arriving while busy defers `done` until after that line's final write.
- Simultaneous `start` and `frame_end` in IDLE: the line is accepted and `done` follows that line.
- `start` while busy is dropped, not queued.
- Reset values: all outputs are 0, state is IDLE, pending is 0. Reset asserted mid-line aborts the line immediately and suppresses any further writes.

## Timing
- Accept at edge E (start=1, busy=0).
- `busy`=1 from E+1 through the cycle holding the last write slot.
- Pixel k (k=0..n) is presented on the outputs in the cycle after edge E+3+k.
- `line_done` is high during pixel n's slot. `busy` falls at the next edge.
- Back-to-back: the next `start` may be accepted on the edge where `busy` falls. The gap between lines is 3 cycles.
- `done` is high in the cycle following the last write slot, or 2 cycles after `frame_end` when already idle.
- Throughput: 1 pixel/clk sustained.

## Structure
- Shared package `fb_pkg`:
  - `H_RES`, `V_RES`, `ADDR_W`, `COLOR_W`.
  - The `drawer_state_t` enum (IDLE, SETUP, DRAW).
  - Must stay consistent with the framebuffer controller's 640×480 addressing.
- One sub-module, `fb_addr_calc`:
  - Registered y*640+x, computed as (y<<9)+(y<<7)+x, plus the clip test.
  - Produces `w_addr` and the clipped `en_w`.

## Test plan
- Horizontal line (0,0)→(3,0), colour 5 → four consecutive writes with addresses 0,1,2,3 and `color_in`=5. `line_done` is high with addr 3.
- Diagonal (10,10)→(12,12) → addresses 6410, 7051, 7692 on consecutive cycles.
- Steep reversed line (5,3)→(4,0) → addresses 1925, 1285, 644, 4.
- Clipped line (-2,0)→(1,0) → four slots: `en_w`=0,0,1,1, with addresses 0 and 1 in the last two slots.
- `frame_end` pulsed mid-line on (0,0)→(9,0) → `done` is a single pulse one cycle after the addr-9 write. No `done` appears before it.
- Reset (`rst`=0) asserted during pixel 2 of a 10-pixel line → `en_w`, `busy`, `done` go to 0 immediately. After release the block stays idle and a new `start` behaves normally.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and drawer state encoding; must match the
// framebuffer controller's 640x480 row-major addressing.
package fb_pkg;

   localparam int H_RES   = 640;
   localparam int V_RES   = 480;
   localparam int ADDR_W  = 19;
   localparam int COLOR_W = 4;
   localparam int CW      = 11;

   // Bits of an on-screen coordinate that feed the address adder
   localparam int XA_W = 10;
   localparam int YA_W = 9;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      DRAW
   } drawer_state_t;

   // y*640 + x without a multiplier: 640 = 512 + 128
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [YA_W-1:0] y,
                                                  input logic [XA_W-1:0] x);
      logic [ADDR_W-1:0] w_y;
      w_y = ADDR_W'(y);
      return (w_y << 9) + (w_y << 7) + ADDR_W'(x);
   endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Registered pixel address stage: clip test plus y*640+x, producing the
// framebuffer write port and the end-of-line marker.
module fb_addr_calc
   import fb_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   input  logic                 i_last,
   input  logic signed [CW-1:0] i_x,
   input  logic signed [CW-1:0] i_y,
   input  logic [COLOR_W-1:0]   i_color,
   output logic [ADDR_W-1:0]    o_addr,
   output logic                 o_en,
   output logic                 o_last,
   output logic [COLOR_W-1:0]   o_color
);

   localparam logic signed [CW-1:0] X_LIM = CW'(H_RES);
   localparam logic signed [CW-1:0] Y_LIM = CW'(V_RES);

   logic w_on_screen;

   assign w_on_screen = !i_x[CW-1] && !i_y[CW-1] && (i_x < X_LIM) && (i_y < Y_LIM);

   // Clipped pixels keep their slot (o_last still fires) but never write
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_addr  <= '0;
         o_en    <= 1'b0;
         o_last  <= 1'b0;
         o_color <= '0;
      end else begin
         o_en   <= i_valid && w_on_screen;
         o_last <= i_valid && i_last;
         o_addr <= (i_valid && w_on_screen) ?
                   pix_addr(i_y[YA_W-1:0], i_x[XA_W-1:0]) : '0;
         if (i_valid) begin
            o_color <= i_color;
         end
      end
   end

endmodule

// File: rtl/fb_line_drawer.sv
// Bresenham line rasteriser feeding the framebuffer write port, one pixel per
// clock, plus the end-of-frame strobe that makes the controller swap buffers.
module fb_line_drawer
   import fb_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic signed [CW-1:0] x0,
   input  logic signed [CW-1:0] y0,
   input  logic signed [CW-1:0] x1,
   input  logic signed [CW-1:0] y1,
   input  logic [COLOR_W-1:0]   color,
   input  logic                 frame_end,
   output logic                 busy,
   output logic                 line_done,
   output logic [ADDR_W-1:0]    w_addr,
   output logic [COLOR_W-1:0]   color_in,
   output logic                 en_w,
   output logic                 done
);

   localparam int EW = CW + 2;

   drawer_state_t        r_state;
   logic                 r_busy;
   logic                 r_pending;
   logic                 r_done;
   logic signed [CW-1:0] r_x;
   logic signed [CW-1:0] r_y;
   logic signed [CW-1:0] r_x1;
   logic signed [CW-1:0] r_y1;
   logic [COLOR_W-1:0]   r_color;
   logic signed [EW-1:0] r_dx;
   logic signed [EW-1:0] r_dy;
   logic signed [EW-1:0] r_err;
   logic [EW-1:0]        r_n;
   logic                 r_sx_neg;
   logic                 r_sy_neg;
   logic                 r_e_valid;
   logic                 r_e_last;
   logic signed [CW-1:0] r_ex;
   logic signed [CW-1:0] r_ey;

   logic                 w_accept;
   logic                 w_fire;
   logic signed [EW-1:0] w_ddx;
   logic signed [EW-1:0] w_ddy;
   logic signed [EW-1:0] w_adx;
   logic signed [EW-1:0] w_ady;
   logic signed [EW:0]   w_e2;
   logic                 w_step_x;
   logic                 w_step_y;
   logic signed [EW-1:0] w_err_next;

   // A command landing in the final write slot overlaps it, leaving a 3-cycle gap
   assign w_accept = start && (!r_busy || line_done);
   assign w_fire   = r_pending && (r_state == IDLE) && !r_e_valid && !w_accept;

   assign w_ddx = $signed({{2{r_x1[CW-1]}}, r_x1}) - $signed({{2{r_x[CW-1]}}, r_x});
   assign w_ddy = $signed({{2{r_y1[CW-1]}}, r_y1}) - $signed({{2{r_y[CW-1]}}, r_y});
   assign w_adx = w_ddx[EW-1] ? -w_ddx : w_ddx;
   assign w_ady = w_ddy[EW-1] ? -w_ddy : w_ddy;

   assign w_e2       = {r_err, 1'b0};
   assign w_step_x   = w_e2 >= $signed({r_dy[EW-1], r_dy});
   assign w_step_y   = w_e2 <= $signed({r_dx[EW-1], r_dx});
   assign w_err_next = r_err + (w_step_x ? r_dy : EW'(0)) + (w_step_y ? r_dx : EW'(0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_busy    <= 1'b0;
         r_pending <= 1'b0;
         r_done    <= 1'b0;
         r_x       <= '0;
         r_y       <= '0;
         r_x1      <= '0;
         r_y1      <= '0;
         r_color   <= '0;
         r_dx      <= '0;
         r_dy      <= '0;
         r_err     <= '0;
         r_n       <= '0;
         r_sx_neg  <= 1'b0;
         r_sy_neg  <= 1'b0;
         r_e_valid <= 1'b0;
         r_e_last  <= 1'b0;
         r_ex      <= '0;
         r_ey      <= '0;
      end else begin
         r_e_valid <= 1'b0;
         r_e_last  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_x     <= x0;
                  r_y     <= y0;
                  r_x1    <= x1;
                  r_y1    <= y1;
                  r_color <= color;
                  r_state <= SETUP;
               end
            end
            SETUP: begin
               r_dx     <= w_adx;
               r_dy     <= -w_ady;
               r_err    <= w_adx - w_ady;
               r_sx_neg <= w_ddx[EW-1];
               r_sy_neg <= w_ddy[EW-1];
               r_n      <= (w_adx >= w_ady) ? w_adx : w_ady;
               r_state  <= DRAW;
            end
            DRAW: begin
               r_e_valid <= 1'b1;
               r_ex      <= r_x;
               r_ey      <= r_y;
               r_e_last  <= (r_n == '0);
               r_err     <= w_err_next;
               if (w_step_x) begin
                  r_x <= r_sx_neg ? r_x - CW'(1) : r_x + CW'(1);
               end
               if (w_step_y) begin
                  r_y <= r_sy_neg ? r_y - CW'(1) : r_y + CW'(1);
               end
               if (r_n == '0) begin
                  r_state <= IDLE;
               end else begin
                  r_n <= r_n - EW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase

         // Busy spans the whole write pipeline, not just the stepping states
         if (w_accept) begin
            r_busy <= 1'b1;
         end else if (line_done) begin
            r_busy <= 1'b0;
         end

         r_done    <= w_fire;
         r_pending <= (r_pending && !w_fire) || frame_end;
      end
   end

   fb_addr_calc u_addr_calc (
      .clk     (clk),
      .rst     (rst),
      .i_valid (r_e_valid),
      .i_last  (r_e_last),
      .i_x     (r_ex),
      .i_y     (r_ey),
      .i_color (r_color),
      .o_addr  (w_addr),
      .o_en    (en_w),
      .o_last  (line_done),
      .o_color (color_in)
   );

   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_fb_line_drawer.sv
// Scoreboard bench for fb_line_drawer: a plain-integer Bresenham model predicts
// every write slot and done pulse with its cycle; a negedge monitor checks them.
module tb_fb_line_drawer;
   import fb_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 start = 1'b0;
   logic signed [CW-1:0] x0 = '0;
   logic signed [CW-1:0] y0 = '0;
   logic signed [CW-1:0] x1 = '0;
   logic signed [CW-1:0] y1 = '0;
   logic [COLOR_W-1:0]   color = '0;
   logic                 frame_end = 1'b0;
   logic                 busy;
   logic                 line_done;
   logic [ADDR_W-1:0]    w_addr;
   logic [COLOR_W-1:0]   color_in;
   logic                 en_w;
   logic                 done;

   fb_line_drawer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .x0        (x0),
      .y0        (y0),
      .x1        (x1),
      .y1        (y1),
      .color     (color),
      .frame_end (frame_end),
      .busy      (busy),
      .line_done (line_done),
      .w_addr    (w_addr),
      .color_in  (color_in),
      .en_w      (en_w),
      .done      (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int addr;
      bit en;
      int col;
      bit last;
   } pix_t;

   pix_t exp_q[$];
   int   done_q[$];
   int   checks = 0;
   int   errors = 0;
   int   line_last = 0;
   pix_t mon_e;
   int   mon_d;

   // Monitor: every write slot (or end-of-line slot) and every done pulse
   always @(negedge clk) begin
      if (rst) begin
         if (en_w || line_done) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_slot cyc=%0d addr=%0d en=%0b last=%0b", cyc, w_addr, en_w, line_done);
            end else begin
               mon_e = exp_q.pop_front();
               if (cyc != mon_e.cyc || en_w != mon_e.en || line_done != mon_e.last ||
                   (mon_e.en && (int'(w_addr) != mon_e.addr || int'(color_in) != mon_e.col))) begin
                  errors++;
                  $display("FAIL pixel got cyc=%0d addr=%0d en=%0b col=%0d last=%0b required cyc=%0d addr=%0d en=%0b col=%0d last=%0b",
                           cyc, w_addr, en_w, color_in, line_done,
                           mon_e.cyc, mon_e.addr, mon_e.en, mon_e.col, mon_e.last);
               end
            end
         end
         if (done) begin
            checks++;
            if (done_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done cyc=%0d", cyc);
            end else begin
               mon_d = done_q.pop_front();
               if (cyc != mon_d) begin
                  errors++;
                  $display("FAIL done_cycle got=%0d required=%0d", cyc, mon_d);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int got, input int expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s got=%0d required=%0d", name, got, expv);
      end
   endtask

   // Reference: classic endpoint-terminated Bresenham on integers
   task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1,
                             input int acol, input int ce, input int keep, output int n);
      int x, y, dx, dy, sx, sy, err, e2, k;
      bit on, last;
      pix_t p;
      x = ax0; y = ay0;
      dx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
      dy = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
      sx = (ax0 < ax1) ? 1 : -1;
      sy = (ay0 < ay1) ? 1 : -1;
      err = dx + dy;
      k = 0;
      while (k < 5000) begin
         on   = (x >= 0) && (x < H_RES) && (y >= 0) && (y < V_RES);
         last = (x == ax1) && (y == ay1);
         if ((on || last) && (keep < 0 || k < keep)) begin
            p.cyc = ce + 3 + k; p.addr = y * H_RES + x; p.en = on; p.col = acol; p.last = last;
            exp_q.push_back(p);
         end
         if (last) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
         k++;
      end
      n = k;
   endtask

   task automatic send_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int acol, input bit fe, input int keep, output int ce);
      int n;
      x0 = ax0[CW-1:0]; y0 = ay0[CW-1:0]; x1 = ax1[CW-1:0]; y1 = ay1[CW-1:0];
      color = acol[COLOR_W-1:0];
      start = 1'b1;
      frame_end = fe;
      @(posedge clk); #1;
      ce = cyc;
      start = 1'b0;
      frame_end = 1'b0;
      model_line(ax0, ay0, ax1, ay1, acol, ce, keep, n);
      line_last = ce + 3 + n;
      if (fe) done_q.push_back(ce + 4 + n);
      $display("line (%0d,%0d)->(%0d,%0d) col=%0d fe=%0b accepted cyc=%0d pixels=%0d",
               ax0, ay0, ax1, ay1, acol, fe, ce, n + 1);
   endtask

   task automatic pulse_fe();
      int cf, d;
      frame_end = 1'b1;
      @(posedge clk); #1;
      frame_end = 1'b0;
      cf = cyc;
      d = (cf + 1 > line_last + 1) ? cf + 1 : line_last + 1;
      done_q.push_back(d);
      $display("frame_end sampled cyc=%0d done expected cyc=%0d", cf, d);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((busy || exp_q.size() != 0 || done_q.size() != 0) && t < 10000) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 10000) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout busy=%0b pending_pixels=%0d pending_done=%0d", busy, exp_q.size(), done_q.size());
         exp_q.delete();
         done_q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int ce;
      int ax, ay;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", int'(busy), 0);
      chk("reset_en_w", int'(en_w), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_line_done", int'(line_done), 0);
      chk("reset_w_addr", int'(w_addr), 0);
      chk("reset_color_in", int'(color_in), 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_busy", int'(busy), 0);

      send_line(0, 0, 3, 0, 5, 1'b0, -1, ce);    wait_idle();
      send_line(10, 10, 12, 12, 3, 1'b0, -1, ce); wait_idle();
      send_line(5, 3, 4, 0, 9, 1'b0, -1, ce);    wait_idle();
      send_line(-2, 0, 1, 0, 7, 1'b0, -1, ce);   wait_idle();

      send_line(0, 0, 9, 0, 2, 1'b0, -1, ce);
      repeat (4) @(posedge clk);
      #1;
      pulse_fe();
      wait_idle();

      pulse_fe();
      wait_idle();

      send_line(1, 1, 6, 4, 12, 1'b1, -1, ce);
      wait_idle();

      send_line(0, 20, 30, 20, 4, 1'b0, -1, ce);
      repeat (5) @(posedge clk);
      #1;
      x0 = 11'sd100; y0 = 11'sd100; x1 = 11'sd120; y1 = 11'sd110;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_during_dropped_start", int'(busy), 1);
      wait_idle();

      send_line(639, 479, 639, 479, 15, 1'b0, -1, ce);    wait_idle();
      send_line(640, 0, 640, 0, 1, 1'b0, -1, ce);         wait_idle();
      send_line(0, 479, 639, 479, 6, 1'b0, -1, ce);       wait_idle();
      send_line(638, 478, 641, 481, 8, 1'b0, -1, ce);     wait_idle();
      send_line(-1024, -1024, 1023, 1023, 10, 1'b0, -1, ce); wait_idle();

      for (int i = 0; i < 30; i++) begin
         ax = int'($urandom_range(719)) - 40;
         ay = int'($urandom_range(559)) - 40;
         send_line(ax, ay, ax + int'($urandom_range(120)) - 60, ay + int'($urandom_range(120)) - 60,
                   int'($urandom_range(15)), 1'($urandom_range(1)), -1, ce);
         wait_idle();
      end

      send_line(0, 5, 9, 5, 6, 1'b0, 3, ce);
      while (cyc < ce + 5) begin
         @(posedge clk); #1;
      end
      #6;
      rst = 1'b0;
      #1;
      chk("rst_mid_en_w", int'(en_w), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_done", int'(done), 0);
      chk("rst_mid_line_done", int'(line_done), 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("post_reset_busy", int'(busy), 0);
      chk("post_reset_queue", exp_q.size(), 0);
      exp_q.delete();

      send_line(2, 2, 5, 6, 11, 1'b1, -1, ce);
      wait_idle();

      chk("final_pixel_queue", exp_q.size(), 0);
      chk("final_done_queue", done_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
